// File: rtl/ifetch_unit.sv
// Instruction fetch stage: computes the next PC, issues word fetches and owns the IF/ID register.
// Define IFETCH_MISALIGN_TRAP_EN to trap on misaligned PCs instead of silently aligning them.
module ifetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_cur,
    output logic [31:0] o_pc_next,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc4,
    output logic        o_fetch_misalign,
    output logic [1:0]  o_state
);

    // Handshakes: o_imem_req with same-cycle i_imem_ack completes a fetch (one outstanding
    // at most); an IF/ID entry is consumed on a rising edge where o_if_id_valid=1 and i_stall=0.
    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef IFETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] S_TRAP  = 2'd3;
`endif

    logic [1:0]  r_state;
    logic [1:0]  w_state_nx;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_if_id_valid;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc4;
    logic        w_req;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_hold_pc4;

    assign w_pc_plus4 = i_pc_cur + 32'd4;
    assign w_hold_pc4 = r_hold_pc + 32'd4;

    always_comb begin
        w_req      = 1'b0;
        w_pc_next  = i_pc_cur;
        w_state_nx = r_state;
        case (r_state)
            S_START: begin
                w_pc_next  = RESET_VECTOR;
                w_state_nx = S_FETCH;
            end
            S_FETCH: begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                if (i_pc_cur[1:0] != 2'b00) begin
                    w_state_nx = S_TRAP;
                end else
`endif
                begin
                    w_req = 1'b1;
                    if (i_imem_ack) begin
                        w_pc_next = w_pc_plus4;
                        if (i_stall) begin
                            w_state_nx = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    w_state_nx = S_FETCH;
                end
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            S_TRAP: begin
                w_state_nx = S_TRAP;
            end
`endif
            default: begin
                w_state_nx = S_START;
            end
        endcase
        // Redirect overrides everything except reset; any same-cycle ack is dropped.
        if (i_redirect) begin
            w_pc_next  = i_redirect_target;
            w_state_nx = S_FETCH;
        end
        if (i_reset) begin
            w_req      = 1'b0;
            w_pc_next  = RESET_VECTOR;
            w_state_nx = S_START;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_START;
            r_hold_instr  <= NOP_WORD;
            r_hold_pc     <= 32'd0;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_WORD;
            r_if_id_pc    <= 32'd0;
            r_if_id_pc4   <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            if (i_redirect) begin
                r_if_id_valid <= 1'b0;
                r_if_id_instr <= NOP_WORD;
                r_hold_instr  <= NOP_WORD;
                r_hold_pc     <= 32'd0;
            end else begin
                case (r_state)
                    S_FETCH: begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                        if (i_pc_cur[1:0] != 2'b00) begin
                            r_if_id_valid <= 1'b0;
                            r_if_id_instr <= NOP_WORD;
                        end else
`endif
                        if (i_imem_ack && !i_stall) begin
                            r_if_id_valid <= 1'b1;
                            r_if_id_instr <= i_imem_rdata;
                            r_if_id_pc    <= i_pc_cur;
                            r_if_id_pc4   <= w_pc_plus4;
                        end else if (i_imem_ack) begin
                            // The PC register moves on, so remember which PC this word belongs to.
                            r_hold_instr <= i_imem_rdata;
                            r_hold_pc    <= i_pc_cur;
                        end else if (!i_stall) begin
                            r_if_id_valid <= 1'b0;
                            r_if_id_instr <= NOP_WORD;
                        end
                    end
                    S_HOLD: begin
                        if (!i_stall) begin
                            r_if_id_valid <= 1'b1;
                            r_if_id_instr <= r_hold_instr;
                            r_if_id_pc    <= r_hold_pc;
                            r_if_id_pc4   <= w_hold_pc4;
                        end
                    end
`ifdef IFETCH_MISALIGN_TRAP_EN
                    S_TRAP: begin
                        r_if_id_valid <= 1'b0;
                        r_if_id_instr <= NOP_WORD;
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_pc_next     = w_pc_next;
    assign o_imem_req    = w_req;
    assign o_imem_addr   = {i_pc_cur[31:2], 2'b00};
    assign o_if_id_valid = r_if_id_valid;
    assign o_if_id_instr = r_if_id_instr;
    assign o_if_id_pc    = r_if_id_pc;
    assign o_if_id_pc4   = r_if_id_pc4;
    assign o_state       = r_state;
`ifdef IFETCH_MISALIGN_TRAP_EN
    assign o_fetch_misalign = !i_reset && (r_state == S_TRAP);
`else
    assign o_fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: IF/ID entries are scoreboarded, control outputs checked inline.
// Build with IFETCH_MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  logic        clk;
  logic        reset;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        fetch_misalign;
  logic [1:0]  state;

  logic        ack_en;
  logic        force_en;
  logic [31:0] force_val;
  logic [31:0] pc_reg;

  int n_checks = 0;
  int n_fail = 0;
  logic [95:0] exp_q[$];
  logic [95:0] mon_exp;

  ifetch_unit dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_pc_cur(pc_cur),
    .o_pc_next(pc_next),
    .o_imem_req(imem_req),
    .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack),
    .i_imem_rdata(imem_rdata),
    .i_stall(stall),
    .i_redirect(redirect),
    .i_redirect_target(redirect_target),
    .o_if_id_valid(if_id_valid),
    .o_if_id_instr(if_id_instr),
    .o_if_id_pc(if_id_pc),
    .o_if_id_pc4(if_id_pc4),
    .o_fetch_misalign(fetch_misalign),
    .o_state(state)
  );

  // clock / PC register / zero-latency memory
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pc_reg <= pc_next;
  assign pc_cur     = force_en ? force_val : pc_reg;
  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = 32'hC0DE_0000 | {16'h0000, imem_addr[15:0]};

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
    exp_q.push_back({instr, pc, pc4});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // monitor: an IF/ID entry is consumed when valid and not stalled
  always @(negedge clk) begin
    if (!reset && if_id_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ifid_unexpected: got pc=%0h instr=%0h, required no entry", if_id_pc, if_id_instr);
      end else begin
        mon_exp = exp_q.pop_front();
        check("ifid_entry", {if_id_instr, if_id_pc, if_id_pc4}, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    ack_en = 1'b1; force_en = 1'b0; force_val = 32'h0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", state, ST_START);
    check("rst_req", imem_req, 0);
    check("rst_pc_next", pc_next, 32'h0);
    check("rst_valid", if_id_valid, 0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_pc", if_id_pc, 0);
    check("rst_pc4", if_id_pc4, 0);
    check("rst_misalign", fetch_misalign, 0);

    // sequential fetch after reset release
    next_cycle(); reset = 1'b0;
    @(negedge clk);
    check("start_req", imem_req, 0);
    check("start_pc_next", pc_next, 32'h0);
    push_exp(32'hC0DE_0000, 32'h0, 32'h4);
    push_exp(32'hC0DE_0004, 32'h4, 32'h8);
    push_exp(32'hC0DE_0008, 32'h8, 32'hC);
    next_cycle();
    @(negedge clk);
    check("f0_state", state, ST_FETCH);
    check("f0_req", imem_req, 1);
    check("f0_addr", imem_addr, 32'h0);
    check("f0_pc_next", pc_next, 32'h4);
    next_cycle();
    @(negedge clk);
    check("f1_addr", imem_addr, 32'h4);
    check("f1_ifid_pc", if_id_pc, 32'h0);
    next_cycle();
    @(negedge clk);
    check("f2_addr", imem_addr, 32'h8);
    check("f2_ifid_pc", if_id_pc, 32'h4);
    next_cycle(); ack_en = 1'b0;
    @(negedge clk);
    check("noack_pc_next", pc_next, 32'hC);
    next_cycle();
    @(negedge clk);
    check("noack_valid", if_id_valid, 0);

    // ack under stall goes to the hold buffer
    next_cycle(); force_en = 1'b1; force_val = 32'h10; ack_en = 1'b1; stall = 1'b1;
    push_exp(32'hC0DE_0010, 32'h10, 32'h14);
    @(negedge clk);
    check("hold_ack_addr", imem_addr, 32'h10);
    check("hold_ack_pc_next", pc_next, 32'h14);
    next_cycle(); force_en = 1'b0;
    @(negedge clk);
    check("hold1_state", state, ST_HOLD);
    check("hold1_req", imem_req, 0);
    check("hold1_pc_next", pc_next, 32'h14);
    check("hold1_valid", if_id_valid, 0);
    next_cycle();
    @(negedge clk);
    check("hold2_pc_next", pc_next, 32'h14);
    check("hold2_state", state, ST_HOLD);
    next_cycle(); stall = 1'b0; ack_en = 1'b0;
    @(negedge clk);
    check("hold3_req", imem_req, 0);
    next_cycle(); ack_en = 1'b1;
    @(negedge clk);
    check("unhold_pc", if_id_pc, 32'h10);
    check("unhold_instr", if_id_instr, 32'hC0DE_0010);
    check("unhold_state", state, ST_FETCH);
    check("unhold_addr", imem_addr, 32'h14);

    // redirect beats stall and a concurrent ack, flushing IF/ID
    next_cycle(); redirect = 1'b1; redirect_target = 32'h200; stall = 1'b1;
    @(negedge clk);
    check("redir_pc_next", pc_next, 32'h200);
    check("redir_pre_valid", if_id_valid, 1);
    check("redir_pre_pc", if_id_pc, 32'h14);
    next_cycle(); redirect = 1'b0; ack_en = 1'b0;
    @(negedge clk);
    check("redir_valid", if_id_valid, 0);
    check("redir_instr", if_id_instr, NOP);
    check("redir_addr", imem_addr, 32'h200);
    check("redir_state", state, ST_FETCH);

    // PC+4 wraps
    next_cycle(); stall = 1'b0; force_en = 1'b1; force_val = 32'hFFFF_FFFC; ack_en = 1'b1;
    push_exp(32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0);
    @(negedge clk);
    check("wrap_pc_next", pc_next, 32'h0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    next_cycle(); force_en = 1'b0; ack_en = 1'b0;
    @(negedge clk);
    check("wrap_pc4", if_id_pc4, 32'h0);

    // reset while in HOLD drops the buffered word
    next_cycle(); force_en = 1'b1; force_val = 32'h40; ack_en = 1'b1; stall = 1'b1;
    @(negedge clk);
    check("rh_pc_next", pc_next, 32'h44);
    next_cycle(); force_en = 1'b0; ack_en = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rh_in_hold", state, ST_HOLD);
    check("rh_req", imem_req, 0);
    check("rh_pc_next_rst", pc_next, 32'h0);
    next_cycle(); reset = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("rh_state", state, ST_START);
    check("rh_valid", if_id_valid, 0);
    check("rh_instr", if_id_instr, NOP);
    check("rh_pc", if_id_pc, 0);
    check("rh_pc4", if_id_pc4, 0);
    check("rh_misalign", fetch_misalign, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rh_no_stale", if_id_valid, 0);

    // misaligned PC
    next_cycle(); force_en = 1'b1; force_val = 32'h102; ack_en = 1'b1;
`ifdef IFETCH_MISALIGN_TRAP_EN
    @(negedge clk);
    check("mis_req", imem_req, 0);
    check("mis_pc_next", pc_next, 32'h102);
    next_cycle(); force_en = 1'b0;
    @(negedge clk);
    check("trap_state", state, ST_TRAP);
    check("trap_flag", fetch_misalign, 1);
    check("trap_req", imem_req, 0);
    check("trap_valid", if_id_valid, 0);
    next_cycle();
    @(negedge clk);
    check("trap_held", fetch_misalign, 1);
    check("trap_pc_next", pc_next, 32'h102);
    next_cycle(); redirect = 1'b1; redirect_target = 32'h100; ack_en = 1'b0;
    @(negedge clk);
    check("trap_redir_pc_next", pc_next, 32'h100);
    next_cycle(); redirect = 1'b0;
    @(negedge clk);
    check("trap_exit_state", state, ST_FETCH);
    check("trap_exit_flag", fetch_misalign, 0);
    check("trap_exit_addr", imem_addr, 32'h100);
`else
    push_exp(32'hC0DE_0100, 32'h102, 32'h106);
    @(negedge clk);
    check("mis_req", imem_req, 1);
    check("mis_addr", imem_addr, 32'h100);
    check("mis_flag", fetch_misalign, 0);
    check("mis_pc_next", pc_next, 32'h106);
    next_cycle(); force_en = 1'b0; ack_en = 1'b0;
    @(negedge clk);
    check("mis_ifid_pc", if_id_pc, 32'h102);
`endif

    next_cycle();
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, pc_next value during and immediately after reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word presented in IF/ID when invalid or flushed.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc_cur  input  32  current PC from the PC register.
REQ-006 pc_next  output  32  next PC to the PC register input; combinational.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 stall  input  1  decode back-pressure; IF/ID holds when high.
REQ-012 redirect  input  1  branch/jump taken; flush and retarget.
REQ-013 redirect_target  input  32  new PC on redirect.
REQ-014 if_id_valid / if_id_instr / if_id_pc / if_id_pc4  output  1/32/32/32  IF/ID pipeline register.
REQ-015 fetch_misalign  output  1  misaligned-fetch trap flag.

Function
REQ-016 The FSM SHALL have states S_START, S_FETCH, S_HOLD and S_TRAP; S_TRAP exists only with the macro.
REQ-017 S_START: imem_req=0, pc_next=RESET_VECTOR; next state S_FETCH unconditionally.
REQ-018 S_FETCH: imem_req=1, imem_addr={pc_cur[31:2],2'b00}; without ack, pc_next=pc_cur and IF/ID holds if stall=1, else loads valid=0.
REQ-019 S_FETCH, ack, stall=0: IF/ID loads valid=1, instr=imem_rdata, pc=pc_cur, pc4=pc_cur+4; pc_next=pc_cur+4; stay in S_FETCH.
REQ-020 S_FETCH, ack, stall=1: imem_rdata is captured into a one-word hold buffer; pc_next=pc_cur+4; IF/ID unchanged; go to S_HOLD.
REQ-021 S_HOLD: imem_req=0, pc_next=pc_cur; when stall=0, IF/ID loads from the buffer (valid=1, pc/pc4 captured) and the FSM returns to S_FETCH; otherwise it stays.
REQ-022 IF/ID SHALL hold all fields whenever stall=1 and no redirect occurs.
REQ-023 redirect SHALL take priority over stall, ack and state: pc_next=redirect_target; next cycle if_id_valid=0 and if_id_instr=NOP_WORD; hold buffer discarded; state S_FETCH.
REQ-024 An ack coinciding with redirect SHALL be discarded.
REQ-025 Abandoning an unacked request on redirect is permitted; imem_addr follows pc_cur on the next cycle.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC gives 32'h0000_0000).
REQ-027 Latency SHALL be one cycle from ack to IF/ID valid when stall=0, with at most one outstanding request.

Reset
REQ-028 While reset=1: state S_START, imem_req=0, pc_next=RESET_VECTOR, if_id_valid=0, if_id_instr=NOP_WORD, if_id_pc=0, if_id_pc4=0, hold buffer cleared, fetch_misalign=0.
REQ-029 Reset asserted mid-request or in S_HOLD SHALL abandon the request and drop the buffered word.

Configuration
REQ-030 Macro IFETCH_MISALIGN_TRAP_EN defined: in S_FETCH with pc_cur[1:0]!=0, no request issues and the FSM enters S_TRAP.
REQ-031 S_TRAP behaviour: imem_req=0, fetch_misalign=1, if_id_valid=0, pc_next=pc_cur; the FSM leaves S_TRAP only on redirect (to S_FETCH) or reset.
REQ-032 Macro undefined: fetch_misalign is tied to 0, S_TRAP is absent, and pc_cur[1:0] is ignored through address alignment.

Verification
REQ-033 Release reset with zero-latency ack and stall=0 -> cycle 1 imem_req=0; then sequential fetches at 0x0, 0x4, 0x8, with if_id_pc trailing imem_addr by one cycle.
REQ-034 Ack at pc=0x10 with stall=1 for 3 cycles -> S_HOLD, imem_req=0, pc_next=0x14 once and then held; on stall release if_id_pc=0x10 with the buffered word.
REQ-035 redirect=1 with target 0x200, concurrent ack, and stall=1 -> ack word dropped, if_id_valid=0 with NOP_WORD, next imem_addr=0x200.
REQ-036 pc_cur=0xFFFF_FFFC with ack -> pc_next=0x0000_0000 and if_id_pc4=0x0.
REQ-037 Macro on, pc_cur=0x102 -> imem_req=0 and fetch_misalign=1 held until redirect to 0x100; macro off -> imem_addr=0x100.
REQ-038 reset asserted in S_HOLD -> next cycle all outputs at reset values and the buffer is empty.
